// File: rtl/acc_ctrl.sv
// ============================================================================
// Module      : acc_ctrl
// Description : Beat-counting controller for a clear/enable accumulator with a
//               valid/ready result handshake and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_ctrl #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  localparam logic [CNTW-1:0] C_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] C_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [CNTW-1:0] r_klen;
  logic [CNTW-1:0] w_klen_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_ZERO;
      r_klen  <= C_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_klen  <= w_klen_nxt;
    end
  end

  // Outputs are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_klen_nxt  = r_klen;
    in_ready    = 1'b0;
    acc_en      = 1'b0;
    acc_clr     = 1'b0;
    out_valid   = 1'b0;
    busy        = rst_n && (r_state != ST_IDLE);

    if (!rst_n) begin
      w_state_nxt = ST_IDLE;
    end else if (flush) begin
      acc_clr     = 1'b1;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = C_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            acc_clr     = 1'b1;
            w_klen_nxt  = k_len;
            w_cnt_nxt   = C_ZERO;
            w_state_nxt = (k_len == C_ZERO) ? ST_HOLD : ST_ACC;
          end
        end
        ST_ACC: begin
          in_ready = 1'b1;
          acc_en   = in_valid;
          if (in_valid) begin
            // cnt tops out at klen_q, so a full-range length never wraps
            w_cnt_nxt = r_cnt + C_ONE;
            if (r_cnt == r_klen - C_ONE) begin
              w_state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          out_valid = 1'b1;
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = C_ZERO;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_ctrl.sv
// ============================================================================
// Module      : tb_acc_ctrl
// Description : Directed cycle-by-cycle checks of acc_ctrl plus a transaction
//               scoreboard of expected beat counts per delivered result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_ctrl;

  localparam int CNTW = 8;

  // Expected output vector: {busy, out_valid, in_ready, acc_en, acc_clr}
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_START = 5'b00001;
  localparam logic [4:0] C_BEAT  = 5'b10110;
  localparam logic [4:0] C_STALL = 5'b10100;
  localparam logic [4:0] C_HOLD  = 5'b11000;
  localparam logic [4:0] C_FLBSY = 5'b10001;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CNTW-1:0] k_len;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            acc_en;
  logic            acc_clr;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int checks;
  int errors;
  int beats;
  int exp_q[$];

  acc_ctrl #(.CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, out_valid, in_ready, acc_en, acc_clr};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs 1ns later, then track
  // beats and retire a scoreboard entry on a completed result handshake.
  task automatic cyc(input string tag, input logic s, input logic [CNTW-1:0] k,
                     input logic iv, input logic fl, input logic ordy,
                     input logic [4:0] exp);
    int e;
    @(negedge clk);
    start = s; k_len = k; in_valid = iv; flush = fl; out_ready = ordy;
    #1;
    check_vec(tag, exp);
    if (acc_clr)     beats = 0;
    else if (acc_en) beats++;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s_result: observed unexpected result expected none", tag);
      end else begin
        e = exp_q.pop_front();
        assert (beats == e) else begin
          errors++;
          $error("FAIL %s_beats: observed %0d expected %0d", tag, beats, e);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; beats = 0;
    rst_n = 1'b0; start = 1'b1; k_len = 8'd3; in_valid = 1'b1;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    check_vec("reset_outputs", C_IDLE);
    @(negedge clk); rst_n = 1'b1; start = 1'b0;

    cyc("idle", 0, 8'd0, 0, 0, 1, C_IDLE);

    // Basic run, k_len=4
    exp_q.push_back(4);
    cyc("basic_start", 1, 8'd4, 1, 0, 1, C_START);
    for (int i = 0; i < 4; i++) cyc("basic_beat", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("basic_hold", 0, 8'd0, 1, 0, 1, C_HOLD);
    cyc("basic_idle", 0, 8'd0, 1, 0, 1, C_IDLE);

    // Stalls, k_len=3, in_valid 1,0,0,1,0,1
    exp_q.push_back(3);
    cyc("stall_start", 1, 8'd3, 0, 0, 1, C_START);
    cyc("stall_b1", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("stall_s1", 0, 8'd0, 0, 0, 1, C_STALL);
    cyc("stall_s2", 0, 8'd0, 0, 0, 1, C_STALL);
    cyc("stall_b2", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("stall_s3", 1, 8'd9, 0, 0, 1, C_STALL);
    cyc("stall_b3", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("stall_hold", 0, 8'd0, 0, 0, 1, C_HOLD);
    cyc("stall_idle", 0, 8'd0, 0, 0, 1, C_IDLE);

    // Back-pressure in HOLD with an ignored start
    exp_q.push_back(1);
    cyc("bp_start", 1, 8'd1, 1, 0, 0, C_START);
    cyc("bp_beat", 0, 8'd0, 1, 0, 0, C_BEAT);
    for (int i = 0; i < 5; i++) cyc("bp_hold", (i == 2), 8'd7, 1, 0, 0, C_HOLD);
    cyc("bp_release", 0, 8'd0, 0, 0, 1, C_HOLD);
    cyc("bp_idle", 0, 8'd0, 0, 0, 1, C_IDLE);

    // Zero length
    exp_q.push_back(0);
    cyc("zero_start", 1, 8'd0, 1, 0, 1, C_START);
    cyc("zero_hold", 0, 8'd0, 1, 0, 1, C_HOLD);
    cyc("zero_idle", 0, 8'd0, 1, 0, 1, C_IDLE);

    // Flush after 2 of 6 beats, then a normal k_len=2 run
    cyc("flush_start", 1, 8'd6, 1, 0, 1, C_START);
    cyc("flush_b1", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("flush_b2", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("flush_acc", 0, 8'd0, 1, 1, 1, C_FLBSY);
    cyc("flush_idle", 0, 8'd0, 1, 0, 1, C_IDLE);
    exp_q.push_back(2);
    cyc("after_start", 1, 8'd2, 1, 0, 1, C_START);
    cyc("after_b1", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("after_b2", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("after_hold", 0, 8'd0, 1, 0, 1, C_HOLD);
    cyc("after_idle", 0, 8'd0, 1, 0, 1, C_IDLE);

    // Flush beats start in IDLE; flush beats out_ready in HOLD
    cyc("flush_vs_start", 1, 8'd5, 1, 1, 1, C_START);
    cyc("flush_vs_start_idle", 0, 8'd0, 1, 0, 1, C_IDLE);
    cyc("flush_hold_start", 1, 8'd0, 0, 0, 0, C_START);
    cyc("flush_hold", 0, 8'd0, 0, 1, 1, C_FLBSY);
    cyc("flush_hold_idle", 0, 8'd0, 0, 0, 1, C_IDLE);

    // Maximum length, 255 beats without wrap
    exp_q.push_back(255);
    cyc("max_start", 1, 8'd255, 1, 0, 1, C_START);
    for (int i = 0; i < 255; i++) cyc("max_beat", 0, 8'd0, 1, 0, 1, C_BEAT);
    cyc("max_hold", 0, 8'd0, 1, 0, 1, C_HOLD);
    cyc("max_idle", 0, 8'd0, 1, 0, 1, C_IDLE);

    // Asynchronous reset mid-ACC, between clock edges
    cyc("ar_start", 1, 8'd5, 1, 0, 1, C_START);
    cyc("ar_b1", 0, 8'd0, 1, 0, 1, C_BEAT);
    @(posedge clk);
    #2;
    rst_n = 1'b0; start = 1'b1;
    #1;
    check_vec("async_reset", C_IDLE);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    cyc("ar_idle", 0, 8'd0, 1, 0, 1, C_IDLE);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_ctrl.md
ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have parameter CNTW, default 8, giving the width of the reduction-length field and beat counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a new accumulation; accepted only in IDLE.
REQ-005 SHALL have port k_len, input, CNTW: number of partial-product beats to accumulate; sampled when start is accepted.
REQ-006 SHALL have port in_valid, input, 1: a partial product is presented to the accumulator this cycle.
REQ-007 SHALL have port in_ready, output, 1: the controller accepts a beat this cycle.
REQ-008 SHALL have port flush, input, 1: synchronous abort of the current accumulation.
REQ-009 SHALL have port acc_en, output, 1: drives the accumulator enable.
REQ-010 SHALL have port acc_clr, output, 1: drives the accumulator synchronous clear.
REQ-011 SHALL have port out_valid, output, 1: the accumulator output holds a final sum.
REQ-012 SHALL have port out_ready, input, 1: the downstream consumer takes the sum.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACC and HOLD, using a CNTW-bit beat counter cnt and a CNTW-bit register klen_q.
REQ-015 IDLE, start=1, k_len!=0: acc_clr=1 combinationally this cycle; klen_q<=k_len, cnt<=0; next state ACC.
REQ-016 IDLE, start=1, k_len==0: acc_clr=1; next state HOLD, so the result is 0.
REQ-017 IDLE, start=0: acc_en=0, acc_clr=0, and state holds.
REQ-018 In ACC, in_ready SHALL be 1, and acc_en SHALL equal in_valid.
REQ-019 A beat is accepted when in_valid&&in_ready; each accepted beat SHALL do cnt<=cnt+1.
REQ-020 When a beat is accepted with cnt==klen_q-1, the next state SHALL be HOLD; the accumulator registers the last sum on that same edge.
REQ-021 In ACC with in_valid=0, the SHALL be no acc_en, no cnt change and no state change; stalls of any length SHALL be tolerated.
REQ-022 In HOLD: out_valid=1, acc_en=0, acc_clr=0, in_ready=0; the sum is held stable.
REQ-023 In HOLD with out_ready=1: next state IDLE; out_valid is a valid/ready handshake and SHALL NOT drop before out_ready.
REQ-024 Latency from the start cycle to out_valid SHALL be k_len+1 cycles when there are no stalls, and 1 cycle when k_len==0.
REQ-025 A start in ACC or HOLD SHALL be ignored, not queued, and k_len SHALL NOT be resampled.
REQ-026 flush=1 in any state SHALL assert acc_clr=1 and force acc_en=0, in_ready=0, out_valid=0, with next state IDLE and cnt<=0.
REQ-027 flush SHALL have priority over start, beats and out_ready in the same cycle.
REQ-028 k_len=2^CNTW-1 SHALL be legal; cnt SHALL NOT wrap before reaching HOLD.
REQ-029 acc_en and acc_clr SHALL never both be 1; if asserted, acc_clr wins.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, cnt=0 and klen_q=0.
REQ-031 With rst_n=0, busy, out_valid, in_ready and acc_en SHALL all be 0, and acc_clr SHALL be 0 because start is ignored during reset.
REQ-032 Reset asserted mid-ACC or mid-HOLD SHALL discard the operation; after release the block SHALL be in IDLE.

Verification
REQ-033 Basic run: start with k_len=4, in_valid held at 1, out_ready=1 -> acc_clr in cycle 0, acc_en in cycles 1-4, out_valid in cycle 5 for 1 cycle, then IDLE.
REQ-034 Stalls: k_len=3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 acc_en pulses, and out_valid the cycle after the 3rd beat.
REQ-035 Back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 with acc_en=0; a start during HOLD is ignored; IDLE follows one cycle after out_ready=1.
REQ-036 Zero length: k_len=0 -> acc_clr in cycle 0, out_valid in cycle 1, no acc_en at all.
REQ-037 Flush: flush asserted after 2 of 6 beats, together with in_valid=1 -> acc_clr=1 and acc_en=0 that cycle, then IDLE; a new start with k_len=2 then completes normally.
REQ-038 Async reset: rst_n pulsed low mid-ACC between clock edges -> busy and out_valid are 0 without waiting for a clock edge, and the block is in IDLE on release.
